// File: rtl/param_counter_if.sv
// param_counter_if
//   Groups the control, configuration and status signals of param_counter.
//   clk and rst are not part of the bundle; they stay plain module ports.
//   Modports:
//     master : drives en, load_en, load_val, dir, mode, limit, cmp_val,
//              clr_flags, oe; observes count_val, count_oe, tc, cmp_match,
//              ovf, running
//     slave  : the counter side (mirror image of master)
interface param_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load_en;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] cmp_val;
  logic             clr_flags;
  logic             oe;
  logic [WIDTH-1:0] count_val;
  logic [WIDTH-1:0] count_oe;
  logic             tc;
  logic             cmp_match;
  logic             ovf;
  logic             running;

  modport master (
    output en, load_en, load_val, dir, mode, limit, cmp_val, clr_flags, oe,
    input  count_val, count_oe, tc, cmp_match, ovf, running
  );

  modport slave (
    input  en, load_en, load_val, dir, mode, limit, cmp_val, clr_flags, oe,
    output count_val, count_oe, tc, cmp_match, ovf, running
  );
endinterface

// File: rtl/param_counter.sv
// param_counter
//   Parametrised up/down counter with a programmable upper limit (range
//   0..limit), wrap / saturate / one-shot terminal behaviour, an enable
//   prescaler, one-cycle terminal-count and compare-match pulses and a sticky
//   overflow flag.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous, active-high reset
//     bus  : param_counter_if.slave
//            in : en, load_en, load_val, dir (1=up), mode (00/11 wrap,
//                 01 saturate, 10 one-shot), limit, cmp_val, clr_flags, oe
//            out: count_val (registered), count_oe ({WIDTH{oe}}, comb),
//                 tc, cmp_match (1-cycle pulses), ovf (sticky), running
module param_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int RST_VAL  = 0
) (
  input logic           clk,
  input logic           rst,
  param_counter_if.slave bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // PRESCALE=1 still gets a 1-bit prescaler that simply never leaves 0.
  localparam int               PSC_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST  = PSC_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RST_VAL);
  localparam logic [1:0]       MODE_SAT  = 2'b01;
  localparam logic [1:0]       MODE_ONE  = 2'b10;

  state_t           state;
  state_t           state_nxt;
  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_nxt;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic             run;
  logic             tick;
  logic             terminal;
  logic             term_tick;
  logic             tc_r;
  logic             cmp_r;
  logic             ovf_r;

  // Value taken on a terminal step. No +1/-1 here, so nothing can wrap
  // through the arithmetic; a count loaded above limit is pulled back to
  // limit when it saturates or stops.
  function automatic logic [WIDTH-1:0] terminal_value(
    input logic [1:0]       m,
    input logic             up,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] lim
  );
    case (m)
      MODE_SAT: terminal_value = up ? lim : '0;
      MODE_ONE: terminal_value = (up && (cur > lim)) ? lim : cur;
      default:  terminal_value = up ? '0 : lim;
    endcase
  endfunction

  always_comb begin
    run       = (state == RUN);
    tick      = bus.en && run && (psc == PSC_LAST);
    terminal  = bus.dir ? (count >= bus.limit) : (count == '0);
    term_tick = tick && terminal && !bus.load_en;
  end

  // Next-state / next-count logic; load always overrides a tick.
  always_comb begin
    state_nxt = state;
    psc_nxt   = psc;
    count_nxt = count;
    if (bus.load_en) begin
      state_nxt = RUN;
      psc_nxt   = '0;
      count_nxt = bus.load_val;
    end else begin
      if (bus.en && run) begin
        psc_nxt = tick ? '0 : psc + PSC_W'(1);
      end
      if (tick) begin
        if (terminal) begin
          count_nxt = terminal_value(bus.mode, bus.dir, count, bus.limit);
          if (bus.mode == MODE_ONE) begin
            state_nxt = HALT;
          end
        end else if (bus.dir) begin
          count_nxt = count + WIDTH'(1);
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Count / prescaler / flag register boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_COUNT;
      psc   <= '0;
      tc_r  <= 1'b0;
      cmp_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      count <= count_nxt;
      psc   <= psc_nxt;
      tc_r  <= term_tick;
      // Only ticks raise compare match; a load landing on cmp_val does not.
      cmp_r <= tick && !bus.load_en && (count_nxt == bus.cmp_val);
      // A terminal step in the same cycle as clr_flags keeps the flag set.
      if (term_tick) begin
        ovf_r <= 1'b1;
      end else if (bus.clr_flags) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign bus.count_val = count;
  assign bus.count_oe  = {WIDTH{bus.oe}};
  assign bus.tc        = tc_r;
  assign bus.cmp_match = cmp_r;
  assign bus.ovf       = ovf_r;
  assign bus.running   = run;

endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter
//   Drives two counters: u_cnt1 (WIDTH=8, PRESCALE=1, RST_VAL=0) through a
//   behavioural model whose predictions are queued per clock edge and popped
//   after the edge, and u_cnt4 (PRESCALE=4, RST_VAL=7) against fixed
//   expectations for prescaler and reset behaviour.
module tb_param_counter;

  logic clk;
  logic rst;

  param_counter_if #(.WIDTH(8)) a ();
  param_counter_if #(.WIDTH(8)) b ();

  param_counter #(.WIDTH(8), .PRESCALE(1), .RST_VAL(0)) u_cnt1 (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  param_counter #(.WIDTH(8), .PRESCALE(4), .RST_VAL(7)) u_cnt4 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] count;
    logic       tc;
    logic       cmp;
    logic       ovf;
    logic       run;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string phase    = "init";

  // Model state for u_cnt1 (PRESCALE=1: every enabled RUN cycle is a tick).
  int m_count;
  bit m_run, m_ovf, m_tc, m_cmp;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_run   = 1'b1;
    m_ovf   = 1'b0;
    m_tc    = 1'b0;
    m_cmp   = 1'b0;
    exp_q.delete();
  endtask

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic model_edge();
    int lim;
    bit up, term, tick;
    lim  = int'(a.limit);
    up   = a.dir;
    m_tc = 1'b0;
    m_cmp = 1'b0;
    if (a.load_en) begin
      m_count = int'(a.load_val);
      m_run   = 1'b1;
      if (a.clr_flags) m_ovf = 1'b0;
    end else begin
      tick = a.en && m_run;
      term = up ? (m_count >= lim) : (m_count == 0);
      if (tick) begin
        if (!term) begin
          m_count = up ? m_count + 1 : m_count - 1;
        end else begin
          case (a.mode)
            2'b01: m_count = up ? lim : 0;
            2'b10: begin
              if (up && m_count > lim) m_count = lim;
              m_run = 1'b0;
            end
            default: m_count = up ? 0 : lim;
          endcase
        end
        m_tc  = term;
        m_cmp = (m_count == int'(a.cmp_val));
      end
      if (tick && term) m_ovf = 1'b1;
      else if (a.clr_flags) m_ovf = 1'b0;
    end
  endtask

  // One clock edge: push the prediction, then pop and compare after the edge.
  task automatic step();
    exp_t e;
    model_edge();
    e.count = 8'(m_count);
    e.tc    = m_tc;
    e.cmp   = m_cmp;
    e.ovf   = m_ovf;
    e.run   = m_run;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq({phase, ".count"},   32'(a.count_val), 32'(e.count));
    check_eq({phase, ".tc"},      32'(a.tc),        32'(e.tc));
    check_eq({phase, ".cmp"},     32'(a.cmp_match), 32'(e.cmp));
    check_eq({phase, ".ovf"},     32'(a.ovf),       32'(e.ovf));
    check_eq({phase, ".running"}, 32'(a.running),   32'(e.run));
  endtask

  task automatic load1(input logic [7:0] v);
    a.load_val = v;
    a.load_en  = 1'b1;
    step();
    a.load_en  = 1'b0;
  endtask

  initial begin : stim
    logic       b_en_pat [5];
    logic [7:0] b_exp_pat[5];
    b_en_pat  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    b_exp_pat = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd8};

    rst = 1'b1;
    a.en = 0; a.load_en = 0; a.load_val = 0; a.dir = 1; a.mode = 0;
    a.limit = 8'd5; a.cmp_val = 8'd3; a.clr_flags = 0; a.oe = 0;
    b.en = 0; b.load_en = 0; b.load_val = 0; b.dir = 1; b.mode = 0;
    b.limit = 8'hFF; b.cmp_val = 8'd0; b.clr_flags = 0; b.oe = 0;
    repeat (2) @(posedge clk);
    #1;

    phase = "reset";
    check_eq("reset.count",   32'(a.count_val), 32'd0);
    check_eq("reset.tc",      32'(a.tc),        32'd0);
    check_eq("reset.cmp",     32'(a.cmp_match), 32'd0);
    check_eq("reset.ovf",     32'(a.ovf),       32'd0);
    check_eq("reset.running", 32'(a.running),   32'd1);
    check_eq("reset.count4",  32'(b.count_val), 32'd7);
    rst = 1'b0;
    model_reset();

    // Wrap up 0..5,0,1 with compare at 3.
    phase = "t1";
    a.en = 1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 2) check_eq("t1.cmp_at3", 32'(a.cmp_match), 32'd1);
      if (i == 4) check_eq("t1.ovf_pre", 32'(a.ovf), 32'd0);
      if (i == 5) begin
        check_eq("t1.wrap_count", 32'(a.count_val), 32'd0);
        check_eq("t1.wrap_tc",    32'(a.tc),        32'd1);
      end
    end

    // Saturate down from 2, clear colliding with a terminal tick.
    phase = "t2";
    a.en = 0; a.clr_flags = 1; step();
    check_eq("t2.ovf_cleared", 32'(a.ovf), 32'd0);
    a.clr_flags = 0; a.mode = 2'b01; a.dir = 0; a.en = 1;
    load1(8'd2);
    for (int i = 0; i < 4; i++) step();
    check_eq("t2.sat_count", 32'(a.count_val), 32'd0);
    check_eq("t2.sat_tc",    32'(a.tc),        32'd1);
    a.clr_flags = 1; step();
    check_eq("t2.ovf_set_wins", 32'(a.ovf), 32'd1);
    a.clr_flags = 0;

    // One-shot up to 3, halt, reload resumes.
    phase = "t3";
    a.mode = 2'b10; a.dir = 1; a.limit = 8'd3; a.cmp_val = 8'd9;
    load1(8'd0);
    for (int i = 0; i < 5; i++) step();
    check_eq("t3.halt_count",   32'(a.count_val), 32'd3);
    check_eq("t3.halt_running", 32'(a.running),   32'd0);
    load1(8'd1);
    check_eq("t3.reload_running", 32'(a.running), 32'd1);
    step();
    check_eq("t3.resume_count", 32'(a.count_val), 32'd2);

    // load_val above limit.
    phase = "t5";
    a.mode = 2'b00; a.limit = 8'd10;
    load1(8'd200); step();
    check_eq("t5.wrap_count", 32'(a.count_val), 32'd0);
    a.mode = 2'b01;
    load1(8'd200); step();
    check_eq("t5.sat_count", 32'(a.count_val), 32'd10);

    // limit==0, down wrap, saturate compare re-pulse.
    phase = "lim0";
    a.mode = 2'b00; a.limit = 8'd0;
    load1(8'd0);
    for (int i = 0; i < 3; i++) step();
    a.mode = 2'b01;
    for (int i = 0; i < 2; i++) step();
    phase = "downwrap";
    a.mode = 2'b00; a.dir = 0; a.limit = 8'd5;
    load1(8'd1);
    for (int i = 0; i < 3; i++) step();
    check_eq("downwrap.count", 32'(a.count_val), 32'd4);
    phase = "sathold";
    a.mode = 2'b01; a.dir = 1; a.limit = 8'd4; a.cmp_val = 8'd4;
    load1(8'd2);
    for (int i = 0; i < 4; i++) step();
    check_eq("sathold.cmp_repulse", 32'(a.cmp_match), 32'd1);

    // Prescaler on u_cnt4 while u_cnt1 idles.
    phase = "t4";
    a.en = 0;
    for (int i = 0; i < 5; i++) begin
      b.en = b_en_pat[i];
      step();
      check_eq($sformatf("t4.psc%0d", i), 32'(b.count_val), 32'(b_exp_pat[i]));
    end
    b.en = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq($sformatf("t4.mid%0d", i), 32'(b.count_val), 32'd8);
    end
    b.load_val = 8'd50; b.load_en = 1; step(); b.load_en = 0;
    check_eq("t4.load", 32'(b.count_val), 32'd50);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("t4.post%0d", i), 32'(b.count_val),
               (i == 3) ? 32'd51 : 32'd50);
    end
    b.en = 0;

    // Randomised mix of all controls.
    phase = "rand";
    for (int i = 0; i < 300; i++) begin
      a.en        = ($urandom_range(0, 3) != 0);
      a.load_en   = ($urandom_range(0, 15) == 0);
      a.load_val  = 8'($urandom_range(0, 255));
      a.dir       = 1'($urandom_range(0, 1));
      a.mode      = 2'($urandom_range(0, 3));
      a.limit     = 8'($urandom_range(0, 12));
      a.cmp_val   = 8'($urandom_range(0, 12));
      a.clr_flags = ($urandom_range(0, 7) == 0);
      step();
    end
    a.load_en = 0; a.clr_flags = 0;

    // Asynchronous reset between edges, then output enable.
    phase = "t6";
    a.mode = 2'b00; a.dir = 1; a.limit = 8'd2; a.en = 1;
    load1(8'd0);
    for (int i = 0; i < 4; i++) step();
    check_eq("t6.ovf_before", 32'(a.ovf), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6.async_count",   32'(a.count_val), 32'd0);
    check_eq("t6.async_ovf",     32'(a.ovf),       32'd0);
    check_eq("t6.async_tc",      32'(a.tc),        32'd0);
    check_eq("t6.async_running", 32'(a.running),   32'd1);
    check_eq("t6.async_count4",  32'(b.count_val), 32'd7);
    @(posedge clk);
    #1;
    check_eq("t6.held_count", 32'(a.count_val), 32'd0);
    rst = 1'b0;
    model_reset();
    a.oe = 1; #1;
    check_eq("t6.oe_on",       32'(a.count_oe),  32'hFF);
    check_eq("t6.oe_on_count", 32'(a.count_val), 32'd0);
    a.oe = 0; #1;
    check_eq("t6.oe_off", 32'(a.count_oe), 32'h00);
    step();
    check_eq("t6.restart_count", 32'(a.count_val), 32'd1);

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
